ssd_scan_decoder: RTL and testbench

Receive-side counterpart of the core's seven-segment display driver. It samples the multiplexed `Anode`/`LED_out` bus, filters out scan-transition glitches, and decodes each segment glyph back to a hex nibble. Once all four digits are captured, it emits the reconstructed 16-bit value through a valid/ready handshake. It serves as a bench-side and board-side monitor of the display path.

---
 rtl/ssd_scan_decoder.sv | 116 +++++++++++
 tb/tb_ssd_scan_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: rebuilds the 16-bit hex value from a multiplexed seven-segment scan bus.
// Define SSD_CHANGE_ONLY_EN to drop completed frames identical to the last emitted one.
module ssd_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Anode,
  input  logic [6:0]  LED_out,
  input  logic        frame_ready,
  input  logic        clr_sticky,
  output logic [15:0] frame_value,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        idle
);
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [10:0] sync1, sync2, prev;
  logic [SW-1:0] dwell;
  logic [TW-1:0] idle_cnt;
  logic [3:0] mask, err_sh, sel;
  logic [15:0] shadow;
  logic [1:0] idx;
  logic [4:0] glyph;
  logic same, one_low, latch, timeout, complete, skip, drop, load;
`ifdef SSD_CHANGE_ONLY_EN
  logic seen;
`endif

  // Returns {err, nibble}; unknown glyphs (blank included) decode as error with nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] g);
    case (g)
      7'b0000001: return 5'h00;
      7'b1001111: return 5'h01;
      7'b0010010: return 5'h02;
      7'b0000110: return 5'h03;
      7'b1001100: return 5'h04;
      7'b0100100: return 5'h05;
      7'b0100000: return 5'h06;
      7'b0001111: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0000100: return 5'h09;
      7'b0001000: return 5'h0a;
      7'b1100000: return 5'h0b;
      7'b0110001: return 5'h0c;
      7'b1000010: return 5'h0d;
      7'b0110000: return 5'h0e;
      7'b0111000: return 5'h0f;
      default:    return 5'h10;
    endcase
  endfunction

  always_comb begin
    sel = ~sync2[10:7];
    same = sync2 == prev;
    one_low = sel != 4'd0 && (sel & (sel - 4'd1)) == 4'd0;
    idx = sel[3] ? 2'd3 : sel[2] ? 2'd2 : sel[1] ? 2'd1 : 2'd0;
    latch = same && one_low && dwell == SW'(STABLE_CYCLES - 2);
    glyph = decode(sync2[6:0]);
    timeout = !latch && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
    complete = mask == 4'hf;
`ifdef SSD_CHANGE_ONLY_EN
    skip = complete && seen && {shadow, |err_sh} == {frame_value, frame_err};
`else
    skip = 1'b0;
`endif
    drop = complete && !skip && frame_valid && !frame_ready;
    load = complete && !skip && !(frame_valid && !frame_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      dwell <= '0;
      idle_cnt <= '0;
      mask <= '0;
      err_sh <= '0;
      shadow <= '0;
      frame_value <= '0;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      idle <= 1'b0;
`ifdef SSD_CHANGE_ONLY_EN
      seen <= 1'b0;
`endif
    end else begin
      sync1 <= {Anode, LED_out};
      sync2 <= sync1;
      prev <= sync2;
      // Saturating at STABLE_CYCLES-1 is what makes a latch happen once per dwell.
      dwell <= !same ? '0 : dwell == SW'(STABLE_CYCLES - 1) ? dwell : dwell + SW'(1);
      idle_cnt <= latch ? '0 : idle_cnt == TW'(TIMEOUT_CYCLES) ? idle_cnt : idle_cnt + TW'(1);
      idle <= latch ? 1'b0 : timeout ? 1'b1 : idle;
      mask <= ((complete || timeout) ? 4'h0 : mask) | (latch ? 4'b0001 << idx : 4'h0);
      if (latch) begin
        shadow[{idx, 2'b00} +: 4] <= glyph[3:0];
        err_sh[idx] <= glyph[4];
      end
      if (load) begin
        frame_value <= shadow;
        frame_err <= |err_sh;
      end
      frame_valid <= load | (frame_valid & ~frame_ready);
      overrun <= drop | (overrun & ~clr_sticky);
`ifdef SSD_CHANGE_ONLY_EN
      seen <= seen | load;
`endif
    end
  end
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: directed scenarios for the seven-segment scan decoder.
module tb_ssd_scan_decoder;
  localparam int TO = 300;
  localparam logic [6:0] G [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  localparam logic [6:0] BLANK = 7'b1111111;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] Anode = 4'hf;
  logic [6:0] LED_out = BLANK;
  logic frame_ready = 1'b0;
  logic clr_sticky = 1'b0;
  logic [15:0] frame_value;
  logic frame_valid, frame_err, overrun, idle;
  int checks = 0;
  int errs = 0;
  int acc = 0;
  logic [15:0] last_val = '0;
  logic last_err = 1'b0;

  ssd_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .Anode(Anode), .LED_out(LED_out),
    .frame_ready(frame_ready), .clr_sticky(clr_sticky),
    .frame_value(frame_value), .frame_valid(frame_valid), .frame_err(frame_err),
    .overrun(overrun), .idle(idle));

  always #5 clk = ~clk;

  // An accept happens on the edge after any low phase with valid and ready both high.
  always @(negedge clk)
    if (rst && frame_valid && frame_ready) begin
      acc = acc + 1;
      last_val = frame_value;
      last_err = frame_err;
    end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] g, input int n);
    Anode = ~(4'b0001 << d);
    LED_out = g;
    step(n);
  endtask

  task automatic scan(input logic [6:0] g0, g1, g2, g3);
    show(0, g0, 40);
    show(1, g1, 40);
    show(2, g2, 40);
    show(3, g3, 40);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Anode = 4'($urandom);
      LED_out = 7'($urandom);
      step(1);
    end
    checks += 5;
    if (frame_value !== 16'h0) begin errs++; $display("FAIL reset_value got %h want 0000", frame_value); end
    if (frame_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", frame_valid); end
    if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", frame_err); end
    if (overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun got %b want 0", overrun); end
    if (idle !== 1'b0) begin errs++; $display("FAIL reset_idle got %b want 0", idle); end
    Anode = 4'hf;
    LED_out = 7'($urandom);
    rst = 1'b1;
    step(TO - 1);
    checks++;
    if (idle !== 1'b0) begin errs++; $display("FAIL idle_early got %b want 0", idle); end
    step(1);
    checks += 2;
    if (idle !== 1'b1) begin errs++; $display("FAIL idle_timeout got %b want 1", idle); end
    if (frame_valid !== 1'b0) begin errs++; $display("FAIL idle_no_frame got %b want 0", frame_valid); end
  endtask

  task automatic test_basic;
    int a0;
    frame_ready = 1'b1;
    a0 = acc;
    scan(G[1], G[2], G[3], G[4]);
    Anode = 4'hf;
    step(10);
    checks += 5;
    if (acc - a0 !== 1) begin errs++; $display("FAIL basic_count got %0d want 1", acc - a0); end
    if (last_val !== 16'h4321) begin errs++; $display("FAIL basic_value got %h want 4321", last_val); end
    if (last_err !== 1'b0) begin errs++; $display("FAIL basic_err got %b want 0", last_err); end
    if (idle !== 1'b0) begin errs++; $display("FAIL basic_idle got %b want 0", idle); end
    if (frame_valid !== 1'b0) begin errs++; $display("FAIL basic_drain got %b want 0", frame_valid); end
    scan(G[1], G[2], G[3], G[4]);
    step(5);
    checks++;
    if (acc - a0 !== 2) begin errs++; $display("FAIL basic_second got %0d want 2", acc - a0); end
  endtask

  task automatic test_glitch;
    int a0;
    a0 = acc;
    show(0, G[1], 40);
    show(1, G[2], 40);
    show(2, G[8], 2);
    show(2, BLANK, 40);
    Anode = 4'b0011;
    LED_out = G[9];
    step(40);
    show(3, G[4], 40);
    step(5);
    checks += 3;
    if (acc - a0 !== 1) begin errs++; $display("FAIL glitch_count got %0d want 1", acc - a0); end
    if (last_val !== 16'h4021) begin errs++; $display("FAIL glitch_value got %h want 4021", last_val); end
    if (last_err !== 1'b1) begin errs++; $display("FAIL glitch_err got %b want 1", last_err); end
  endtask

  task automatic test_backpressure;
    int a0;
    frame_ready = 1'b0;
    scan(G[5], G[6], G[7], G[8]);
    checks += 3;
    if (frame_valid !== 1'b1) begin errs++; $display("FAIL bp_hold_valid got %b want 1", frame_valid); end
    if (frame_value !== 16'h8765) begin errs++; $display("FAIL bp_hold_value got %h want 8765", frame_value); end
    if (overrun !== 1'b0) begin errs++; $display("FAIL bp_no_overrun got %b want 0", overrun); end
    scan(G[9], G[10], G[11], G[12]);
    checks += 2;
    if (frame_value !== 16'h8765) begin errs++; $display("FAIL bp_kept_value got %h want 8765", frame_value); end
    if (overrun !== 1'b1) begin errs++; $display("FAIL bp_overrun got %b want 1", overrun); end
    clr_sticky = 1'b1;
    step(1);
    clr_sticky = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errs++; $display("FAIL bp_clear got %b want 0", overrun); end
    show(0, G[13], 40);
    show(1, G[14], 40);
    show(2, G[15], 40);
    show(3, G[0], 6);
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
    checks += 3;
    if (frame_valid !== 1'b1) begin errs++; $display("FAIL bp_same_valid got %b want 1", frame_valid); end
    if (frame_value !== 16'h0fed) begin errs++; $display("FAIL bp_same_value got %h want 0fed", frame_value); end
    if (overrun !== 1'b0) begin errs++; $display("FAIL bp_same_overrun got %b want 0", overrun); end
    step(33);
    a0 = acc;
    frame_ready = 1'b1;
    step(3);
    checks += 2;
    if (acc - a0 !== 1 || last_val !== 16'h0fed) begin
      errs++;
      $display("FAIL bp_drain got %0d/%h want 1/0fed", acc - a0, last_val);
    end
    if (frame_valid !== 1'b0) begin errs++; $display("FAIL bp_drain_valid got %b want 0", frame_valid); end
  endtask

  task automatic test_reset_mid;
    int a0;
    frame_ready = 1'b1;
    show(0, G[7], 40);
    show(1, G[7], 40);
    Anode = 4'hf;
    rst = 1'b0;
    #1;
    checks++;
    if (frame_value !== 16'h0) begin errs++; $display("FAIL mid_async got %h want 0000", frame_value); end
    step(3);
    rst = 1'b1;
    a0 = acc;
    show(2, G[5], 40);
    show(3, G[6], 40);
    checks += 2;
    if (acc - a0 !== 0) begin errs++; $display("FAIL mid_partial got %0d want 0", acc - a0); end
    if (frame_valid !== 1'b0) begin errs++; $display("FAIL mid_valid got %b want 0", frame_valid); end
    show(0, G[1], 40);
    show(1, G[2], 40);
    checks++;
    if (acc - a0 !== 1 || last_val !== 16'h6521) begin
      errs++;
      $display("FAIL mid_full got %0d/%h want 1/6521", acc - a0, last_val);
    end
  endtask

  task automatic test_repeat;
    int a0, exp;
`ifdef SSD_CHANGE_ONLY_EN
    exp = 1;
`else
    exp = 3;
`endif
    frame_ready = 1'b1;
    a0 = acc;
    for (int i = 0; i < 3; i++) scan(G[15], G[0], G[0], G[11]);
    step(5);
    checks += 2;
    if (acc - a0 !== exp) begin errs++; $display("FAIL repeat_count got %0d want %0d", acc - a0, exp); end
    if (last_val !== 16'hb00f) begin errs++; $display("FAIL repeat_value got %h want b00f", last_val); end
    scan(G[8], G[0], G[0], G[11]);
    step(5);
    checks += 2;
    if (acc - a0 !== exp + 1) begin errs++; $display("FAIL change_count got %0d want %0d", acc - a0, exp + 1); end
    if (last_val !== 16'hb008) begin errs++; $display("FAIL change_value got %h want b008", last_val); end
    checks++;
    if (overrun !== 1'b0) begin errs++; $display("FAIL repeat_overrun got %b want 0", overrun); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_backpressure;
    test_reset_mid;
    test_repeat;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
